// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-stage bus bundle: branch redirect, instruction-memory request and
// response channels, and the decode-facing instruction stream.
// master = fetch stage, slave = its environment (ALU, imem, decode).
interface fetch_prefetch_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  redirect_en;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_resp_valid;
  logic [DATA_WIDTH-1:0] imem_resp_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [ADDR_WIDTH-1:0] out_pc_next;

  modport master (
    input  redirect_en, redirect_addr, imem_req_ready, imem_resp_valid,
           imem_resp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
           out_pc_next
  );

  modport slave (
    output redirect_en, redirect_addr, imem_req_ready, imem_resp_valid,
           imem_resp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
           out_pc_next
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Prefetching fetch stage: issues sequential fetches to a variable-latency
// instruction memory, buffers in-order responses in a DEPTH-entry FIFO and
// hands them to decode over valid/ready. A branch redirect flushes the FIFO
// and marks every in-flight response as stale so it is dropped on return.
// Requests are credit-limited (occupancy + outstanding < DEPTH), so a
// response can always be pushed.
// Optional: define FETCH_PERF_COUNTERS_EN to add saturating 32-bit
// perf_fetched / perf_starve / perf_flushed counters.
module fetch_prefetch_queue #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    DEPTH           = 4,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter logic [ADDR_WIDTH-1:0] INITIAL_PC      = 'h10,
  parameter int                    PC_STEP         = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_prefetch_queue_if.master bus
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_starve,
  output logic [31:0]           perf_flushed
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         occ_q, occ_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic [CW-1:0]         stale_q, stale_d;
  logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q    [DEPTH];

  logic          redirect, resp, fire, push, pop, credit_ok, cap_ok;
  logic [CW:0]   inflight;

  assign redirect  = bus.redirect_en;
  assign resp      = bus.imem_resp_valid;
  assign inflight  = {1'b0, occ_q} + {1'b0, outst_q};
  assign credit_ok = inflight < (CW+1)'(DEPTH);
  assign cap_ok    = outst_q < CW'(MAX_OUTSTANDING);

  assign bus.imem_req_valid = !reset && !redirect && credit_ok && cap_ok;
  assign bus.imem_req_addr  = pc_q;
  assign fire = bus.imem_req_valid && bus.imem_req_ready;

  // Head is zeroed whenever the FIFO is empty so decode never sees stale data.
  assign bus.out_valid   = (occ_q != '0);
  assign bus.out_instr   = bus.out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign bus.out_pc      = bus.out_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign bus.out_pc_next = bus.out_valid ? pc_mem_q[rd_ptr_q] + ADDR_WIDTH'(PC_STEP) : '0;

  // A redirect kills both the same-cycle push and pop.
  assign push = resp && (stale_q == '0) && !redirect;
  assign pop  = bus.out_valid && bus.out_ready && !redirect;

  // Next-state for PCs, FIFO pointers and the outstanding/stale counters.
  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    outst_d   = outst_q + CW'(fire) - CW'(resp);
    stale_d   = stale_q;
    if (redirect) begin
      pc_d      = bus.redirect_addr;
      resp_pc_d = bus.redirect_addr;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      occ_d     = '0;
      // Everything still in flight, minus the response dropped right now.
      stale_d   = outst_q - CW'(resp);
    end else begin
      if (fire) pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
      if (push) begin
        resp_pc_d = resp_pc_q + ADDR_WIDTH'(PC_STEP);
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      occ_d = occ_q + CW'(push) - CW'(pop);
      if (resp && (stale_q != '0)) stale_d = stale_q - CW'(1);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= INITIAL_PC;
      resp_pc_q <= INITIAL_PC;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      outst_q   <= '0;
      stale_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      outst_q   <= outst_d;
      stale_q   <= stale_d;
    end
  end

  // FIFO storage; entries are only meaningful below occ_q, so no reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_resp_data;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    push |-> (occ_q != CW'(DEPTH)));

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetched_q, starve_q, flushed_q, flush_amt;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign flush_amt = redirect ? (32'(occ_q) + 32'(resp))
                              : 32'(resp && (stale_q != '0));

  // Saturating event counters for popped, starved and discarded instructions.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      starve_q  <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= sat_add(fetched_q, 32'(pop));
      starve_q  <= sat_add(starve_q, 32'(!bus.out_valid && bus.out_ready));
      flushed_q <= sat_add(flushed_q, flush_amt);
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_starve  = starve_q;
  assign perf_flushed = flushed_q;
`endif

endmodule
